uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped serial transmitter that sits downstream of the processor datapath's output port. It consumes the byte the datapath drives on an output port, together with that port's write strobe, and queues it in a small FIFO. It serialises each byte as an 8N1 UART frame on `tx`. A status byte is returned to the datapath on an input port so firmware can poll for free space and completion.

## Interface
Parameters:
- `DIV`, 16: clock cycles per UART bit; legal range 2..256.
- `DEPTH`, 4: FIFO depth in bytes; power of two, 2..16.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  one-cycle write strobe; the output-port write enable qualified by port select.
- `data_in`  in  8  byte to transmit; the output-port register value, sampled when `wr_en`=1.
- `clr_ovf`  in  1  clears the sticky overflow flag.
- `tx`  out  1  serial line; idle high; registered.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's stop bit.
- `status`  out  8  {4'b0, ovf, full, empty, busy}; wired to an input port.

## Operation
- FIFO:
  - `count` runs 0..DEPTH; `empty`=(count==0); `full`=(count==DEPTH).
  - Read and write pointers wrap modulo DEPTH.
- Write:
  - When `wr_en`=1 and `full`=0 before the edge, `data_in` is stored at the edge.
  - When `wr_en`=1 and `full`=1, the byte is dropped and `ovf` is set. This holds even if a pop happens on the same edge: full is evaluated against pre-edge count.
- `ovf`:
  - Sticky; cleared by `clr_ovf`=1 or reset.
  - If set and clear occur on the same edge, set wins.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If FIFO not empty, pop the head into an 8-bit shift register, load the bit counter with DIV-1, and go to START.
  - START: `tx`=0 for DIV cycles, then go to DATA with `bitidx`=0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts DIV cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: `tx`=1 for DIV cycles. On the last cycle, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `busy` = (state != IDLE).
- A write and a pop on the same edge update `count` by net 0. A write into an empty FIFO while the FSM is in IDLE cannot pop on that same edge.
- Bit counter: a down-counter of width ceil(log2(DIV)). It reloads to DIV-1 on every bit boundary, so every bit lasts exactly DIV cycles.

## Timing
- Reset values:
  - `tx`=1, `tx_done`=0, `status`=8'h02 (empty only).
  - State IDLE, FIFO pointers and count 0, `ovf`=0.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), the frame is aborted, and FIFO contents are discarded.
- Latency, for a write at edge k into an empty FIFO with the FSM in IDLE:
  - `empty` falls after edge k.
  - Pop at edge k+1; `tx` falls and `busy` rises after edge k+1, and `empty` returns high.
- Frame length: exactly 10*DIV cycles from the `tx` falling edge to the next start bit (back-to-back) or to IDLE.
- `tx_done` is high for the one cycle preceding the STOP exit edge.
- `status` is combinational from registered state, so the value is valid the cycle after any updating edge.

## Test plan
- Reset and single byte (DIV=4, DEPTH=4):
  - During and after reset, `tx`=1 and `status`=8'h02.
  - Write 8'hA5 at edge k. `tx` shows the 40-cycle sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit, starting after edge k+1.
  - `tx_done` pulses once; then `status`=8'h02.
- Back-to-back: write 8'h01, 8'h80, 8'hFF on consecutive cycles.
  - Three frames with no idle cycle between stop and start bits.
  - `busy` stays 1 for exactly 120 cycles.
  - Three `tx_done` pulses.
- Full and overflow: with the FSM mid-frame, write 5 bytes while DEPTH=4 slots are free.
  - `full`=1 after the 4th write; the 5th is dropped and `ovf`=1, giving `status` bit3=1.
  - Only the first 4 bytes are transmitted.
  - `clr_ovf` pulse clears bit3.
- Simultaneous write with a full FIFO on a STOP-exit pop edge: the write is dropped, `ovf`=1, and `count` becomes DEPTH-1.
- Reset mid-frame: assert `reset` during data bit 3 of 8'h00.
  - `tx`=1 immediately; `status`=8'h02.
  - A queued second byte is never sent.
- DIV=2 corner: 8'h55 produces alternating `tx` bits of 2 cycles each; frame of 20 cycles.

Source files
------------

// File: rtl/uart_tx_port.sv
// 8N1 serial transmitter fed from a datapath output port.
// Bytes queue in a small FIFO; status exposes ovf/full/empty/busy.
module uart_tx_port #(
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       tx_done,
  output logic [7:0] status
);

  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_INC  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_INC  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    shift_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic          tx_q, done_q, ovf_q;
  logic          empty, full, push, pop, bit_end;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign bit_end = (cnt_q == '0);
  assign push    = wr_en && !full;
  // Pop either from IDLE or on the STOP exit edge, so frames chain with no gap.
  assign pop     = !empty &&
                   ((state_q == IDLE) || (state_q == STOP && bit_end));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_INC;
      2'b01:   count_d = count_q - CNT_INC;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + PTR_INC;
      if (pop)  rd_q <= rd_q + PTR_INC;
      count_q <= count_d;
      if (wr_en && full)  ovf_q <= 1'b1;
      else if (clr_ovf)   ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_q];
            cnt_q   <= CNT_TOP;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= CNT_TOP;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= CNT_TOP;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= CNT_TOP;
            if (pop) begin
              shift_q <= mem_q[rd_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q  <= cnt_q - CNT_ONE;
            // Registered, so raise it one cycle early to land on the last stop cycle.
            done_q <= (cnt_q == CNT_ONE);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign status  = {4'b0000, ovf_q, full, empty, state_q != IDLE};

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomized scoreboard bench for uart_tx_port.
// A frame-level model predicts line waveform and status every cycle.
module tb_uart_tx_port;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, clr_ovf;
  logic [7:0] data_in;
  logic       tx, tx_done;
  logic [7:0] status;

  logic       wr2;
  logic [7:0] d2;
  logic       tx2, done2;
  logic [7:0] status2;
  logic       clr2;

  int ncmp = 0;
  int nerr = 0;

  uart_tx_port #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .data_in (data_in),
    .clr_ovf (clr_ovf),
    .tx      (tx),
    .tx_done (tx_done),
    .status  (status)
  );

  uart_tx_port #(.DIV(2), .DEPTH(4)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr2),
    .data_in (d2),
    .clr_ovf (clr2),
    .tx      (tx2),
    .tx_done (done2),
    .status  (status2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic [7:0] mfifo[$];
  frame_t     frames[$];
  logic       movf = 1'b0;
  int         ecnt = 0;
  int         last_pop = -100000;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line level of an 8N1 frame at cycle offset off (0 = first start-bit cycle).
  function automatic logic exp_bit(input logic [7:0] b, input int off,
                                   input int div);
    int i;
    i = off / div;
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  int pre;
  bit dpop;

  initial forever begin
    @(posedge clk);
    ecnt++;
    if (reset) begin
      mfifo.delete();
      frames.delete();
      movf     = 1'b0;
      last_pop = -100000;
    end else begin
      pre  = mfifo.size();
      dpop = (pre > 0) && (ecnt >= last_pop + FRAME);
      if (dpop) begin
        frames.push_back('{b: mfifo.pop_front(), start: ecnt});
        last_pop = ecnt;
      end
      if (wr_en && pre < DEPTH) mfifo.push_back(data_in);
      if (wr_en && pre == DEPTH) movf = 1'b1;
      else if (clr_ovf)          movf = 1'b0;
    end
  end

  logic       etx, edone;
  logic [7:0] est;
  int         off;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      etx   = 1'b1;
      edone = 1'b0;
      if (frames.size() > 0 && ecnt >= frames[0].start) begin
        off   = ecnt - frames[0].start;
        etx   = exp_bit(frames[0].b, off, DIV);
        edone = (off == FRAME - 1);
      end
      est = {4'b0000, movf, mfifo.size() == DEPTH, mfifo.size() == 0,
             ecnt < last_pop + FRAME};
      check("line", 32'({tx, tx_done, status}), 32'({etx, edone, est}));
      if (edone) void'(frames.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish by 1ms");
    $fatal(1);
  end

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    data_in = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mfifo.size() != 0 || ecnt < last_pop + FRAME) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      ncmp++;
      nerr++;
      $display("FAIL idle_timeout: got busy, required idle");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_edge(input int target);
    int n;
    n = 0;
    while (ecnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      ncmp++;
      nerr++;
      $display("FAIL edge_timeout: got %0d, required %0d", ecnt, target);
    end
  endtask

  int busy_n;
  int s;

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    data_in = 8'h00;
    clr_ovf = 1'b0;
    wr2     = 1'b0;
    d2      = 8'h00;
    clr2    = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_status", 32'(status), 32'h02);
    check("rst_tx2", 32'(tx2), 32'd1);
    check("rst_status2", 32'(status2), 32'h02);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // DIV=2 corner on the second instance
    wr2 = 1'b1;
    d2  = 8'h55;
    @(negedge clk);
    wr2 = 1'b0;
    check("d2_pending_status", 32'(status2), 32'h00);
    check("d2_pending_tx", 32'(tx2), 32'd1);
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      check("d2_frame", 32'({tx2, done2}),
            32'({exp_bit(8'h55, j, 2), j == 19}));
      @(negedge clk);
    end
    check("d2_idle", 32'({tx2, done2, status2}), 32'({1'b1, 1'b0, 8'h02}));

    // Single byte
    wr(8'hA5);
    wait_idle();
    check("a5_status", 32'(status), 32'h02);

    // Back-to-back frames and busy duration
    wr_en   = 1'b1;
    data_in = 8'h01;
    @(negedge clk);
    data_in = 8'h80;
    busy_n  = 0;
    @(negedge clk);
    data_in = 8'hFF;
    busy_n += int'(status[0]);
    @(negedge clk);
    wr_en = 1'b0;
    for (int j = 0; j < 150; j++) begin
      busy_n += int'(status[0]);
      @(negedge clk);
    end
    check("b2b_busy_cycles", 32'(busy_n), 32'd120);
    wait_idle();

    // Overflow while mid-frame
    wr(8'h11);
    repeat (10) @(negedge clk);
    wr(8'h21);
    wr(8'h22);
    wr(8'h23);
    check("ovf_not_full", 32'(status[3:2]), 32'b00);
    wr(8'h24);
    check("ovf_full", 32'(status[3:2]), 32'b01);
    wr(8'h25);
    check("ovf_set", 32'(status[3:2]), 32'b11);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(status[3]), 32'd0);
    wait_idle();

    // Write into full FIFO on the STOP-exit pop edge
    wr(8'h31);
    wr(8'h32);
    wr(8'h33);
    wr(8'h34);
    wr(8'h35);
    wait_edge(last_pop + FRAME - 1);
    wr(8'hEE);
    check("popedge_drop", 32'(status[3:2]), 32'b10);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      data_in = 8'($urandom);
      clr_ovf = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    wait_idle();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    @(negedge clk);

    // Reset during data bit 3 of 8'h00 with a second byte queued
    wr(8'h00);
    wr(8'h3C);
    s = last_pop;
    wait_edge(s + 4 * DIV + 1);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_status", 32'(status), 32'h02);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("postrst_status", 32'(status), 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
